// File: rtl/sdn_parser_word_fetch_unit.sv
// Word fetch stage of the SDN parser: 2-entry skid FIFO feeding a registered word slot
// that tracks per-packet word index and bit address for the extraction units.
module sdn_parser_word_fetch_unit #(
    parameter int unsigned PRS_DATA_W   = 512,
    parameter int unsigned PRS_OFFSET_W = 32,
    parameter int unsigned PRS_COUNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    fetch_en_i,
    input  logic                    fetch_flush_i,
    input  logic                    s_valid_i,
    input  logic [PRS_DATA_W-1:0]   s_data_i,
    input  logic                    s_last_i,
    output logic                    s_ready_o,
    input  logic                    word_hold_i,
    output logic                    word_valid_o,
    output logic [PRS_DATA_W-1:0]   word_data_o,
    output logic [PRS_COUNT_W-1:0]  word_count_o,
    output logic [PRS_OFFSET_W-1:0] word_addr_o,
    output logic                    word_last_o,
    output logic                    header_start_o,
    output logic                    pkt_done_o
);

    logic [PRS_DATA_W-1:0]   fifo_data_q [2];
    logic                    fifo_last_q [2];
    logic                    rd_ptr_q, wr_ptr_q;
    logic [1:0]              occ_q;

    logic                    valid_q, last_q, hs_q;
    logic [PRS_DATA_W-1:0]   data_q;
    logic [PRS_COUNT_W-1:0]  count_q, next_count_q;
    logic [PRS_OFFSET_W-1:0] addr_q;

    logic                    accept, consume, loadable, fifo_empty;
    logic                    bypass, pop, push, load;
    logic [PRS_DATA_W-1:0]   load_data;
    logic                    load_last;
    logic [PRS_COUNT_W-1:0]  succ_count, load_count;
    logic [PRS_OFFSET_W-1:0] load_addr;

    always_comb begin
        s_ready_o  = ~fetch_flush_i & (occ_q != 2'd2);
        accept     = s_valid_i & s_ready_o;
        consume    = valid_q & fetch_en_i & ~word_hold_i;
        loadable   = ~valid_q | consume;
        fifo_empty = (occ_q == 2'd0);
        // An accepted beat skips the FIFO only when nothing older is queued.
        bypass     = fifo_empty & accept & loadable;
        pop        = loadable & ~fifo_empty;
        push       = accept & ~bypass;
        load       = pop | bypass;
        load_data  = fifo_empty ? s_data_i : fifo_data_q[rd_ptr_q];
        load_last  = fifo_empty ? s_last_i : fifo_last_q[rd_ptr_q];
        succ_count = last_q ? '0 : count_q + PRS_COUNT_W'(1);
        load_count = consume ? succ_count : next_count_q;
        load_addr  = PRS_OFFSET_W'(load_count) * PRS_OFFSET_W'(PRS_DATA_W);
        pkt_done_o = consume & last_q & resetn & ~fetch_flush_i;
    end

    always_ff @(posedge clk) begin
        if (!resetn || fetch_flush_i) begin
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            hs_q         <= 1'b0;
            data_q       <= '0;
            count_q      <= '0;
            next_count_q <= '0;
            addr_q       <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= s_data_i;
                fifo_last_q[wr_ptr_q] <= s_last_i;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
            // next_count_q only matters when the slot drains empty after a consume.
            if (consume) begin
                next_count_q <= succ_count;
                valid_q      <= 1'b0;
            end
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= load_data;
                last_q  <= load_last;
                count_q <= load_count;
                addr_q  <= load_addr;
            end
            hs_q <= load & (load_count == '0);
        end
    end

    assign word_valid_o   = valid_q;
    assign word_data_o    = data_q;
    assign word_count_o   = count_q;
    assign word_addr_o    = addr_q;
    assign word_last_o    = last_q;
    assign header_start_o = hs_q;

endmodule

// File: tb/tb_sdn_parser_word_fetch_unit.sv
// Bench for sdn_parser_word_fetch_unit: directed table, hand-written corner sequences and
// random traffic, all compared against a queue-based reference model.
module tb_sdn_parser_word_fetch_unit;

    localparam int DW = 512;
    localparam int OW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          resetn, fetch_en, flush, s_valid, s_last, s_ready, hold;
    logic [DW-1:0] s_data, w_data;
    logic          w_valid, w_last, hs, pd;
    logic [CW-1:0] w_count;
    logic [OW-1:0] w_addr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sdn_parser_word_fetch_unit #(
        .PRS_DATA_W  (DW),
        .PRS_OFFSET_W(OW),
        .PRS_COUNT_W (CW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .fetch_en_i    (fetch_en),
        .fetch_flush_i (flush),
        .s_valid_i     (s_valid),
        .s_data_i      (s_data),
        .s_last_i      (s_last),
        .s_ready_o     (s_ready),
        .word_hold_i   (hold),
        .word_valid_o  (w_valid),
        .word_data_o   (w_data),
        .word_count_o  (w_count),
        .word_addr_o   (w_addr),
        .word_last_o   (w_last),
        .header_start_o(hs),
        .pkt_done_o    (pd)
    );

    // Reference model: pending words as a queue plus one presentation slot.
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;
    beat_t         mq[$];
    logic          mv = 0, ml = 0, mhs = 0, mloaded = 0;
    logic [DW-1:0] md = '0;
    logic [CW-1:0] mc = '0, mnext = '0;

    typedef struct {
        logic rst_n, fl, en, hd, sv, sl;
        logic [7:0] tag;
        logic e_valid;
        logic [7:0] e_tag;
        int unsigned e_cnt;
        logic e_last, e_hs, e_pd, e_rdy;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [DW-1:0] tw(input logic [7:0] t);
        return {64{t}};
    endfunction

    function automatic logic [DW-1:0] dw(input int unsigned k);
        return {16{32'hD000_0000 + k}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic fl, input logic en, input logic hd,
                         input logic sv, input logic sl, input logic [DW-1:0] d);
        resetn = rn; flush = fl; fetch_en = en; hold = hd;
        s_valid = sv; s_last = sl; s_data = d;
    endtask

    task automatic step();
        logic     exp_rdy, exp_pd, cons, acc;
        logic [63:0] a;
        beat_t    b;
        @(negedge clk);
        exp_rdy = !flush && (mq.size() < 2);
        exp_pd  = resetn && !flush && mv && ml && fetch_en && !hold;
        if (chk_en) begin
            chk("m_s_ready", s_ready, exp_rdy);
            chk("m_word_valid", w_valid, mv);
            chk("m_header_start", hs, mhs);
            chk("m_pkt_done", pd, exp_pd);
            if (mv || !mloaded) begin
                a = 64'(mc) * 64'(DW);
                chk("m_word_data", w_data, md);
                chk("m_word_count", w_count, mc);
                chk("m_word_addr", w_addr, a[OW-1:0]);
                chk("m_word_last", w_last, ml);
            end
        end
        if (!resetn || flush) begin
            mq.delete();
            mv = 0; md = '0; ml = 0; mc = '0; mhs = 0; mnext = '0; mloaded = 0;
        end else begin
            cons = mv && fetch_en && !hold;
            acc  = s_valid && exp_rdy;
            if (cons) begin
                mnext = ml ? '0 : mc + 1;
                mv    = 0;
            end
            if (acc) mq.push_back('{s_data, s_last});
            mhs = 0;
            if (!mv && mq.size() > 0) begin
                b = mq.pop_front();
                mv = 1; md = b.d; ml = b.l; mc = mnext; mhs = (mnext == 0); mloaded = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst_n fl en hd sv sl tag | e_valid e_tag e_cnt e_last e_hs e_pd e_rdy
        vecs[0] = '{1, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1};
        vecs[1] = '{1, 0, 1, 0, 1, 0, 8'hA0, 0, 8'h00, 0, 0, 0, 0, 1};
        vecs[2] = '{1, 0, 1, 0, 1, 0, 8'hA1, 1, 8'hA0, 0, 0, 1, 0, 1};
        vecs[3] = '{1, 0, 1, 0, 1, 1, 8'hA2, 1, 8'hA1, 1, 0, 0, 0, 1};
        vecs[4] = '{1, 0, 1, 0, 1, 1, 8'hB0, 1, 8'hA2, 2, 1, 0, 1, 1};
        vecs[5] = '{1, 0, 1, 0, 1, 1, 8'hC0, 1, 8'hB0, 0, 1, 1, 1, 1};
        vecs[6] = '{1, 0, 1, 0, 0, 0, 8'h00, 1, 8'hC0, 0, 1, 1, 1, 1};
        vecs[7] = '{1, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1};

        drive(0, 0, 1, 0, 0, 0, '0);
        step();
        step();
        chk_en = 1'b1;

        // 3-word packet then two single-word packets
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rst_n, vecs[i].fl, vecs[i].en, vecs[i].hd, vecs[i].sv, vecs[i].sl,
                  tw(vecs[i].tag));
            #1;
            chk("tbl_valid", w_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk("tbl_data", w_data, tw(vecs[i].e_tag));
                chk("tbl_count", w_count, CW'(vecs[i].e_cnt));
                chk("tbl_addr", w_addr, OW'(vecs[i].e_cnt * DW));
                chk("tbl_last", w_last, vecs[i].e_last);
            end
            chk("tbl_hs", hs, vecs[i].e_hs);
            chk("tbl_pd", pd, vecs[i].e_pd);
            chk("tbl_ready", s_ready, vecs[i].e_rdy);
            step();
        end

        // Hold word 1 for four cycles while the stream keeps offering
        drive(1, 0, 1, 0, 1, 0, dw(0)); step();
        drive(1, 0, 1, 0, 1, 0, dw(1)); step();
        drive(1, 0, 1, 1, 1, 0, dw(2)); step();
        drive(1, 0, 1, 1, 1, 0, dw(3)); step();
        drive(1, 0, 1, 1, 1, 1, dw(4)); #1;
        chk("hold_ready_low", s_ready, 1'b0);
        chk("hold_data_stable", w_data, dw(1));
        step();
        drive(1, 0, 1, 1, 1, 1, dw(4)); step();
        drive(1, 0, 1, 0, 1, 1, dw(4)); step();
        drive(1, 0, 1, 0, 1, 1, dw(4)); step();
        drive(1, 0, 1, 0, 0, 0, '0); step();
        drive(1, 0, 1, 0, 0, 0, '0); #1;
        chk("hold_tail_data", w_data, dw(4));
        chk("hold_tail_count", w_count, CW'(4));
        chk("hold_tail_pd", pd, 1'b1);
        step();

        // Flush with FIFO full and output valid
        drive(1, 0, 1, 0, 1, 0, dw(16)); step();
        drive(1, 0, 1, 1, 1, 0, dw(17)); step();
        drive(1, 0, 1, 1, 1, 0, dw(18)); step();
        drive(1, 1, 1, 1, 1, 0, dw(19)); #1;
        chk("flush_ready_low", s_ready, 1'b0);
        step();
        drive(1, 0, 1, 0, 0, 0, '0); #1;
        chk("flush_valid_low", w_valid, 1'b0);
        chk("flush_ready_high", s_ready, 1'b1);
        step();
        drive(1, 0, 1, 0, 1, 1, dw(20)); step();
        drive(1, 0, 1, 0, 0, 0, '0); #1;
        chk("flush_next_count", w_count, CW'(0));
        chk("flush_next_hs", hs, 1'b1);
        step();

        // fetch_en low for three cycles mid-packet
        drive(1, 0, 1, 0, 1, 0, dw(32)); step();
        drive(1, 0, 1, 0, 1, 0, dw(33)); step();
        drive(1, 0, 0, 0, 1, 0, dw(34)); step();
        drive(1, 0, 0, 0, 1, 1, dw(35)); step();
        drive(1, 0, 0, 0, 0, 0, '0); #1;
        chk("en_frozen_data", w_data, dw(33));
        chk("en_frozen_pd", pd, 1'b0);
        step();
        drive(1, 0, 1, 0, 0, 0, '0); step();
        drive(1, 0, 1, 0, 0, 0, '0); #1;
        chk("en_resume_count", w_count, CW'(2));
        step();
        drive(1, 0, 1, 0, 0, 0, '0); step();

        // Synchronous reset mid-packet
        drive(1, 0, 1, 0, 1, 0, dw(48)); step();
        drive(1, 0, 1, 0, 1, 0, dw(49)); step();
        drive(0, 0, 1, 0, 0, 0, '0); step();
        drive(1, 0, 1, 0, 0, 0, '0); #1;
        chk("rst_valid", w_valid, 1'b0);
        chk("rst_data", w_data, '0);
        chk("rst_count", w_count, '0);
        chk("rst_addr", w_addr, '0);
        chk("rst_ready", s_ready, 1'b1);
        step();
        drive(1, 0, 1, 0, 1, 1, dw(50)); step();
        drive(1, 0, 1, 0, 0, 0, '0); #1;
        chk("rst_next_count", w_count, CW'(0));
        chk("rst_next_hs", hs, 1'b1);
        step();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(199) != 0), ($urandom_range(79) == 0),
                  ($urandom_range(4) != 0), ($urandom_range(3) == 0),
                  ($urandom_range(9) < 7), ($urandom_range(2) == 0),
                  {16{$urandom}});
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
